// File: rtl/print_pkg.sv
// Shared encodings for the print formatter: request modes, control characters, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package print_pkg;

    // Request mode encodings as seen on the mode input
    localparam logic [1:0] MODE_BYTE  = 2'b00;
    localparam logic [1:0] MODE_HEX   = 2'b01;
    localparam logic [1:0] MODE_NL    = 2'b10;
    localparam logic [1:0] MODE_HEXNL = 2'b11;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_BYTE = 3'd2,
        ST_DIG  = 3'd3,
        ST_SEPC = 3'd4,
        ST_CR   = 3'd5,
        ST_LF   = 3'd6,
        ST_ACK  = 3'd7
    } state_t;

endpackage

// File: rtl/print_hex2ascii.sv
// Nibble to ASCII hex digit converter ('0'-'9', then 'a'-'f' or 'A'-'F').
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input nibble.
// Ports: i_nib - 4-bit value; o_chr - ASCII character.
module print_hex2ascii #(
    parameter bit UPPER = 1'b0
) (
    input  logic [3:0] i_nib,
    output logic [7:0] o_chr
);
    import print_pkg::*;

    always_comb begin
        o_chr = 8'h30 + {4'h0, i_nib};
        if (i_nib > 4'd9) begin
            // 8'h37 + 10 = 'A', 8'h57 + 10 = 'a'
            o_chr = (UPPER ? 8'h37 : 8'h57) + {4'h0, i_nib};
        end
    end

endmodule

// File: rtl/print_fmt.sv
// Formats one latched print request (byte / hex word / CR LF / hex + CR LF) into an ASCII stream.
// Latency: request seen in IDLE -> first vld_tx two cycles later; one cycle minimum per character.
// Backpressure: vld_tx/d_tx hold until rdy_tx; the FSM waits indefinitely, no timeout.
// Ports: clk, rstn (async active-low); req_tx/mode/zsup/dout_tx request in, ack_tx/busy status out;
//        d_tx/vld_tx/rdy_tx character stream to the UART transmitter.
module print_fmt #(
    parameter int         DATA_W = 32,
    parameter int         GROUP  = 4,
    parameter logic [7:0] SEP    = 8'h5F,
    parameter int         UPPER  = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_tx,
    input  logic [1:0]        mode,
    input  logic              zsup,
    input  logic [DATA_W-1:0] dout_tx,
    output logic              ack_tx,
    output logic              busy,
    output logic [7:0]        d_tx,
    output logic              vld_tx,
    input  logic              rdy_tx
);
    import print_pkg::*;

    localparam int                N       = DATA_W / 4;
    localparam int                IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned       GDIV    = (GROUP == 0) ? 1 : GROUP;
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(N - 1);

    // Latched request
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_mode;
    logic              r_zsup;

    // FSM state, digit index (counts down from MSB nibble), leading-zero flag
    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_lead;

    // Registered outputs
    logic              r_ack;
    logic              r_busy;
    logic              r_vld;
    logic [7:0]        r_dat;

    state_t            w_state_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_lead_nxt;

    logic              w_xfer;
    logic [3:0]        w_nib_cur;
    logic              w_skip_cur;
    logic              w_grp_end;

    logic [3:0]        w_nib_nxt;
    logic              w_skip_nxt;
    logic [7:0]        w_dig_chr;
    logic              w_vld_nxt;
    logic [7:0]        w_dat_nxt;
    logic              w_ack_nxt;
    logic              w_busy_nxt;

    function automatic logic [3:0] nib_at(input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i);
        logic [DATA_W-1:0] s;
        s = d >> {i, 2'b00};
        return s[3:0];
    endfunction

    assign w_xfer     = r_vld & rdy_tx;
    assign w_nib_cur  = nib_at(r_data, r_idx);
    // A leading zero is dropped silently, but the last nibble always prints so 0 shows as "0"
    assign w_skip_cur = r_lead && (w_nib_cur == 4'h0) && (r_idx != '0);
    // Separators sit above every GROUP-th nibble counted from the LSB
    assign w_grp_end  = (GROUP != 0) && ((32'(r_idx) % GDIV) == 32'd0);

    // State register, request latch and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_lead  <= 1'b0;
            r_data  <= '0;
            r_mode  <= MODE_BYTE;
            r_zsup  <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_vld   <= 1'b0;
            r_dat   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_lead  <= w_lead_nxt;
            if (r_state == ST_IDLE && req_tx) begin
                r_data <= dout_tx;
                r_mode <= mode;
                r_zsup <= zsup;
            end
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            r_vld   <= w_vld_nxt;
            r_dat   <= w_dat_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_lead_nxt  = r_lead;
        case (r_state)
            ST_IDLE: begin
                if (req_tx) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_idx_nxt  = IDX_TOP;
                w_lead_nxt = r_zsup;
                case (r_mode)
                    MODE_BYTE: w_state_nxt = ST_BYTE;
                    MODE_NL:   w_state_nxt = ST_CR;
                    default:   w_state_nxt = ST_DIG;
                endcase
            end
            ST_BYTE: begin
                if (w_xfer) w_state_nxt = ST_ACK;
            end
            ST_DIG: begin
                if (r_idx > IDX_TOP) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_skip_cur) begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end else begin
                    w_lead_nxt = 1'b0;
                    if (w_xfer) begin
                        if (r_idx == '0) begin
                            w_state_nxt = (r_mode == MODE_HEXNL) ? ST_CR : ST_ACK;
                        end else if (w_grp_end) begin
                            w_state_nxt = ST_SEPC;
                        end else begin
                            w_idx_nxt = r_idx - IDX_W'(1);
                        end
                    end
                end
            end
            ST_SEPC: begin
                if (w_xfer) begin
                    w_idx_nxt   = r_idx - IDX_W'(1);
                    w_state_nxt = ST_DIG;
                end
            end
            ST_CR: begin
                if (w_xfer) w_state_nxt = ST_LF;
            end
            ST_LF: begin
                if (w_xfer) w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values are derived from the upcoming state so the outputs themselves are registered
    assign w_nib_nxt  = nib_at(r_data, w_idx_nxt);
    assign w_skip_nxt = w_lead_nxt && (w_nib_nxt == 4'h0) && (w_idx_nxt != '0);

    print_hex2ascii #(
        .UPPER (UPPER != 0)
    ) u_hex2ascii (
        .i_nib (w_nib_nxt),
        .o_chr (w_dig_chr)
    );

    always_comb begin
        w_vld_nxt  = 1'b0;
        w_dat_nxt  = 8'h00;
        w_ack_nxt  = (w_state_nxt == ST_ACK);
        w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_ACK);
        case (w_state_nxt)
            ST_BYTE: begin
                w_vld_nxt = 1'b1;
                w_dat_nxt = 8'(r_data);
            end
            ST_DIG: begin
                if (!w_skip_nxt && (w_idx_nxt <= IDX_TOP)) begin
                    w_vld_nxt = 1'b1;
                    w_dat_nxt = w_dig_chr;
                end
            end
            ST_SEPC: begin
                w_vld_nxt = 1'b1;
                w_dat_nxt = SEP;
            end
            ST_CR: begin
                w_vld_nxt = 1'b1;
                w_dat_nxt = CHAR_CR;
            end
            ST_LF: begin
                w_vld_nxt = 1'b1;
                w_dat_nxt = CHAR_LF;
            end
            default: begin
                w_vld_nxt = 1'b0;
                w_dat_nxt = 8'h00;
            end
        endcase
    end

    assign ack_tx = r_ack;
    assign busy   = r_busy;
    assign vld_tx = r_vld;
    assign d_tx   = r_dat;

endmodule
